// File: rtl/alarm_ctrl_if.sv
// Mode, key, time and status signals shared between the alarm controller and its surroundings.
interface alarm_ctrl_if;
    logic [1:0]  en;
    logic        arm;
    logic        key_stop_n;
    logic        key_snooze_n;
    logic [19:0] time_sec;
    logic [19:0] alarm_sec;
    logic        ring;
    logic        beep;
    logic [1:0]  state;
    logic [2:0]  snooze_cnt;

    modport master (
        output en, arm, key_stop_n, key_snooze_n, time_sec, alarm_sec,
        input  ring, beep, state, snooze_cnt
    );

    modport slave (
        input  en, arm, key_stop_n, key_snooze_n, time_sec, alarm_sec,
        output ring, beep, state, snooze_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: idle / armed / ringing / snoozed, driven by a 1 Hz tick.
// Define ALARM_SNOOZE_EN for snooze support; otherwise the snooze key acts as a second stop key.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int DAY_SEC    = 86400
) (
    input  logic         clk_1s,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RING  = 2'd2;
    localparam logic [1:0] S_SNZ   = 2'd3;

    localparam int TMR_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RING_SEC - 1);

    logic [1:0]       state_q, state_d;
    logic             ring_q, ring_d;
    logic             beep_q, beep_d;
    logic [2:0]       snz_q, snz_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [19:0]      target;
    logic             stop_key, snz_key, force_idle, match;

    assign force_idle = bus.en[1] | ~bus.arm;
    assign match      = (bus.time_sec == target);

`ifdef ALARM_SNOOZE_EN
    logic [19:0] target_q, target_d;

    function automatic logic [19:0] snooze_target(input logic [19:0] t);
        logic [20:0] s;
        s = {1'b0, t} + 21'(SNOOZE_SEC);
        if (s >= 21'(DAY_SEC))
            s = s - 21'(DAY_SEC);
        return s[19:0];
    endfunction

    assign stop_key = ~bus.key_stop_n;
    assign snz_key  = ~bus.key_snooze_n;
    assign target   = target_q;

    // target follows alarm_sec whenever the next state is ARMED, and is reprogrammed on snooze
    always_comb begin
        target_d = target_q;
        if (state_d == S_ARMED)
            target_d = bus.alarm_sec;
        else if (state_q == S_RING && state_d == S_SNZ)
            target_d = snooze_target(bus.time_sec);
    end

    always_ff @(posedge clk_1s or negedge rst_n) begin
        if (!rst_n) target_q <= '0;
        else        target_q <= target_d;
    end
`else
    assign stop_key = ~bus.key_stop_n | ~bus.key_snooze_n;
    assign snz_key  = 1'b0;
    assign target   = bus.alarm_sec;
`endif

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        beep_d  = beep_q;
        snz_d   = snz_q;
        tmr_d   = tmr_q;
        if (force_idle) begin
            state_d = S_IDLE;
            ring_d  = 1'b0;
            beep_d  = 1'b0;
            snz_d   = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (match) begin
                        state_d = S_RING;
                        ring_d  = 1'b1;
                        beep_d  = 1'b1;
                        tmr_d   = '0;
                    end
                end
                S_RING: begin
                    // a snooze press at the limit falls through to the timeout check
                    if (stop_key) begin
                        state_d = S_ARMED;
                        snz_d   = '0;
                        ring_d  = 1'b0;
                        beep_d  = 1'b0;
                    end else if (snz_key && (snz_q < 3'(MAX_SNOOZE))) begin
                        state_d = S_SNZ;
                        snz_d   = snz_q + 3'd1;
                        ring_d  = 1'b0;
                        beep_d  = 1'b0;
                    end else if (tmr_q == TMR_LAST) begin
                        state_d = S_ARMED;
                        snz_d   = '0;
                        ring_d  = 1'b0;
                        beep_d  = 1'b0;
                    end else begin
                        tmr_d  = tmr_q + 1'b1;
                        beep_d = ~beep_q;
                    end
                end
                default: begin
                    if (stop_key) begin
                        state_d = S_ARMED;
                        snz_d   = '0;
                    end else if (match) begin
                        state_d = S_RING;
                        ring_d  = 1'b1;
                        beep_d  = 1'b1;
                        tmr_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_1s or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ring_q  <= 1'b0;
            beep_q  <= 1'b0;
            snz_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            beep_q  <= beep_d;
            snz_q   <= snz_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.ring       = ring_q;
    assign bus.beep       = beep_q;
    assign bus.snooze_cnt = snz_q;
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencing controller for the clock experiment. It compares the running time of day against the stored alarm time and runs the alarm state machine: idle, armed, ringing and snoozed. It drives the ring/beep outputs and handles stop and snooze keys. It sits beside the alarm-time register block, shares its `en` mode bus, and steps back to idle whenever that block is in alarm-edit mode.

## Interface
- `RING_SEC`, 60 — ring duration in `clk_1s` cycles before auto-stop.
- `SNOOZE_SEC`, 300 — snooze delay in seconds.
- `MAX_SNOOZE`, 3 — snoozes allowed per alarm event; range 1..7.
- `DAY_SEC`, 86400 — seconds per day; the snooze target wraps at this value.

Ports:
- `clk_1s` input 1 — 1 Hz system tick; all state is updated on its rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `en` input 2 — mode bus. Values 2 and 3 (`en[1]`=1) mean alarm-edit mode.
- `arm` input 1 — alarm enable switch; 1 = armed.
- `key_stop_n` input 1 — stop key, active-low, sampled each cycle.
- `key_snooze_n` input 1 — snooze key, active-low, sampled each cycle.
- `time_sec` input 20 — current time of day in seconds.
- `alarm_sec` input 20 — programmed alarm time in seconds.
- `ring` output 1 — 1 while in RINGING.
- `beep` output 1 — buzzer drive; toggles every cycle while ringing.
- `state` output 2 — current state: 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE.
- `snooze_cnt` output 3 — snoozes used in the current alarm event.

## Operation
- Internal registers:
  - `target` (20-bit): the time to match. Loaded from `alarm_sec` on entry to ARMED.
  - `ring_tmr`: counts RINGING cycles.
- Force-idle: `en[1]`=1 or `arm`=0 sends the block to IDLE from any state. This has the highest priority. It also clears `snooze_cnt`, `ring`, `beep` and `ring_tmr`.
- IDLE: moves to ARMED when `arm`=1 and `en[1]`=0.
- ARMED: moves to RINGING when `time_sec == target`.
  - `target` tracks `alarm_sec` every cycle while in ARMED.
- RINGING: checked in this priority order.
  1. Stop key (`key_stop_n`=0): go to ARMED, clear `snooze_cnt`.
  2. Snooze key (`key_snooze_n`=0) with `snooze_cnt < MAX_SNOOZE`: go to SNOOZE.
     - Increment `snooze_cnt`.
     - `target = time_sec + SNOOZE_SEC`; if the sum ≥ `DAY_SEC`, subtract `DAY_SEC`.
     - The sum is computed at 21 bits so it cannot overflow.
  3. Snooze key with `snooze_cnt == MAX_SNOOZE`: ignored; stay RINGING.
  4. `ring_tmr == RING_SEC-1`: go to ARMED, clear `snooze_cnt`.
- SNOOZE:
  - Stop key: go to ARMED, clear `snooze_cnt`.
  - `time_sec == target`: go to RINGING.
- `ring_tmr` is cleared on every entry to RINGING, including re-entry from SNOOZE.
- Match is a full 20-bit equality. `time_sec` values ≥ `DAY_SEC` never match a wrapped target.
- Entering ARMED while `time_sec` already equals `alarm_sec` rings on the next edge.

## Timing
- Reset values: `state`=0, `ring`=0, `beep`=0, `snooze_cnt`=0, `target`=0, `ring_tmr`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: a condition sampled at edge N appears on `state` and `ring` at edge N.
  - Example: `time_sec` equals `target` before edge N, so `ring`=1 after edge N.
- `beep`:
  - Set to 1 on the edge that enters RINGING.
  - Inverts on each following RINGING edge.
  - Set to 0 on the edge that leaves RINGING.
- An unkeyed RINGING episode lasts exactly `RING_SEC` cycles.
- Stop and snooze asserted together: stop wins.
- A key held across cycles acts only in the states listed above; there is no edge detection.
- Reset asserted mid-ring: all outputs clear immediately, asynchronously.

## Configuration
- `ALARM_SNOOZE_EN` defined: full snooze behaviour as described above.
- `ALARM_SNOOZE_EN` undefined:
  - SNOOZE state is unreachable.
  - `key_snooze_n` acts as a stop key, with lower priority than `key_stop_n`.
  - `snooze_cnt` is tied to 0.
  - `target` always equals `alarm_sec`.

## Test plan
- Reset then `arm`=1, `en`=0, `alarm_sec`=100, `time_sec` stepping 98→101:
  - `state`=1, then RINGING after the edge where `time_sec`=100.
  - `beep` sequence 1,0,1…
- Ring unkeyed with `RING_SEC`=60:
  - `ring` high for exactly 60 cycles, then `state`=1, `beep`=0, `snooze_cnt`=0.
- Snooze with `ALARM_SNOOZE_EN`, `time_sec`=86300:
  - `target`=200 (wrapped), `state`=3, `snooze_cnt`=1.
  - Rings again when `time_sec`=200.
- Fourth snooze press with `MAX_SNOOZE`=3:
  - Ignored; `state` stays 2, `snooze_cnt`=3.
  - Stop then gives `state`=1, `snooze_cnt`=0.
- `en`=2 mid-ring: next edge `state`=0, `ring`=0. Same check for `arm`=0 during SNOOZE.
- `rst_n` pulsed low mid-cycle while ringing: outputs clear without waiting for a clock edge. Also drive stop and snooze together: stop wins.
